// File: rtl/hc165_pkg.sv
// Shared constants for the 74HC165 scan controller: default widths/timing
// and the one-hot FSM state encoding.
package hc165_pkg;

  localparam int W_DEFAULT      = 16;
  localparam int MCLK_HZ        = 40_000_000;
  localparam int SCAN_HZ        = 1_000;
  localparam int PERIOD_DEFAULT = MCLK_HZ / SCAN_HZ;
  localparam int DEB_N_DEFAULT  = 3;
  localparam int TMO_DEFAULT    = 4096;

  // state    | meaning
  // IDLE     | waiting for a pending scan request
  // START    | RD_START pulse, timeout counter cleared
  // WAIT     | waiting for reader done edge or timeout
  // EVAL     | debounce/publish the captured sample
  localparam int         ST_W     = 4;
  localparam logic [3:0] ST_IDLE  = 4'b0001;
  localparam logic [3:0] ST_START = 4'b0010;
  localparam logic [3:0] ST_WAIT  = 4'b0100;
  localparam logic [3:0] ST_EVAL  = 4'b1000;

endpackage

// File: rtl/hc165_debounce.sv
// Debounce of reader samples: a candidate word must repeat DEB_N times in a
// row before it is published as the stable image. Tracks changed bits and IRQ.
module hc165_debounce
  import hc165_pkg::*;
#(
  parameter int W     = W_DEFAULT,
  parameter int DEB_N = DEB_N_DEFAULT
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         eval_i,
  input  logic         deb_clr_i,
  input  logic         irq_clr_i,
  input  logic [W-1:0] sample_i,
  output logic [W-1:0] stable_o,
  output logic [W-1:0] chg_mask_o,
  output logic         valid_o,
  output logic         irq_o
);

  localparam logic [3:0] DEB_TGT = 4'(DEB_N);

  logic [W-1:0] cand_q, cand_d;
  logic [3:0]   cnt_q, cnt_d;
  logic [W-1:0] stable_q, stable_d;
  logic [W-1:0] mask_q, mask_d;
  logic         valid_q, valid_d;
  logic         irq_q, irq_d;

  // Candidate tracking, publish decision and change-mask accumulation.
  // A clear coinciding with a publish keeps only the freshly changed bits.
  always_comb begin
    cand_d   = cand_q;
    cnt_d    = cnt_q;
    stable_d = stable_q;
    valid_d  = valid_q;
    mask_d   = irq_clr_i ? '0 : mask_q;
    if (deb_clr_i) begin
      cnt_d = '0;
    end else if (eval_i) begin
      if (sample_i == cand_q) begin
        cnt_d = (cnt_q >= DEB_TGT) ? DEB_TGT : cnt_q + 4'd1;
      end else begin
        cand_d = sample_i;
        cnt_d  = 4'd1;
      end
      if (cnt_d == DEB_TGT && (cand_d != stable_q || !valid_q)) begin
        stable_d = cand_d;
        valid_d  = 1'b1;
        if (valid_q) begin
          mask_d = mask_d | (cand_d ^ stable_q);
        end
      end
    end
    irq_d = |mask_d;
  end

  // Debounce state registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cand_q   <= '0;
      cnt_q    <= '0;
      stable_q <= '0;
      mask_q   <= '0;
      valid_q  <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      cand_q   <= cand_d;
      cnt_q    <= cnt_d;
      stable_q <= stable_d;
      mask_q   <= mask_d;
      valid_q  <= valid_d;
      irq_q    <= irq_d;
    end
  end

  assign stable_o   = stable_q;
  assign chg_mask_o = mask_q;
  assign valid_o    = valid_q;
  assign irq_o      = irq_q;

endmodule

// File: rtl/hc165_scan_ctrl.sv
// Scan scheduler for the 16-bit 74HC165 reader: periodic/one-shot triggering,
// per-read timeout, and hand-off of captured words to the debouncer.
module hc165_scan_ctrl
  import hc165_pkg::*;
#(
  parameter int W      = W_DEFAULT,
  parameter int PERIOD = PERIOD_DEFAULT,
  parameter int DEB_N  = DEB_N_DEFAULT,
  parameter int TMO    = TMO_DEFAULT
) (
  input  logic         MCLK,
  input  logic         RESET,
  input  logic         SCAN_EN,
  input  logic         SCAN_REQ,
  output logic         RD_START,
  input  logic         RD_DONE,
  input  logic [W-1:0] RD_DATA,
  output logic [W-1:0] STABLE_Q,
  output logic [W-1:0] CHG_MASK,
  output logic         VALID,
  output logic         IRQ,
  input  logic         IRQ_CLR,
  output logic         BUSY,
  output logic         TMO_ERR
);

  localparam int               PER_W    = $clog2(PERIOD);
  localparam int               TMO_W    = $clog2(TMO);
  localparam logic [PER_W-1:0] PER_LAST = PER_W'(PERIOD - 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TMO - 1);

  logic [ST_W-1:0]  state_q, state_d;
  logic [PER_W-1:0] per_cnt_q, per_cnt_d;
  logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
  logic [W-1:0]     sample_q, sample_d;
  logic             pend_q, pend_d;
  logic             done_q;
  logic             tmo_err_q, tmo_err_d;
  logic             done_rise, tick, tmo_hit, eval_stb;

  assign done_rise = RD_DONE & ~done_q;
  assign tick      = SCAN_EN && (per_cnt_q == PER_LAST);
  assign eval_stb  = (state_q == ST_EVAL);

  // Period counter: free-runs while enabled, parked at zero otherwise.
  always_comb begin
    per_cnt_d = '0;
    if (SCAN_EN && !tick) begin
      per_cnt_d = per_cnt_q + PER_W'(1);
    end
  end

  // Single-deep request latch; a new request in the START cycle survives the clear.
  always_comb begin
    pend_d = (pend_q & (state_q != ST_START)) | tick | SCAN_REQ;
  end

  // Scan sequencing; a done edge in the last timeout cycle still counts as data.
  always_comb begin
    state_d   = state_q;
    tmo_cnt_d = tmo_cnt_q;
    sample_d  = sample_q;
    tmo_hit   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (pend_q) state_d = ST_START;
      end
      ST_START: begin
        tmo_cnt_d = '0;
        state_d   = ST_WAIT;
      end
      ST_WAIT: begin
        if (done_rise) begin
          sample_d = RD_DATA;
          state_d  = ST_EVAL;
        end else if (tmo_cnt_q == TMO_LAST) begin
          tmo_hit = 1'b1;
          state_d = ST_IDLE;
        end else begin
          tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
        end
      end
      ST_EVAL: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Sticky timeout flag; a new timeout beats a simultaneous clear.
  always_comb begin
    tmo_err_d = tmo_err_q;
    if (tmo_hit) begin
      tmo_err_d = 1'b1;
    end else if (IRQ_CLR) begin
      tmo_err_d = 1'b0;
    end
  end

  // Controller registers.
  always_ff @(posedge MCLK or posedge RESET) begin
    if (RESET) begin
      state_q   <= ST_IDLE;
      per_cnt_q <= '0;
      tmo_cnt_q <= '0;
      sample_q  <= '0;
      pend_q    <= 1'b0;
      done_q    <= 1'b0;
      tmo_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      per_cnt_q <= per_cnt_d;
      tmo_cnt_q <= tmo_cnt_d;
      sample_q  <= sample_d;
      pend_q    <= pend_d;
      done_q    <= RD_DONE;
      tmo_err_q <= tmo_err_d;
    end
  end

  hc165_debounce #(
    .W     (W),
    .DEB_N (DEB_N)
  ) u_deb (
    .clk_i      (MCLK),
    .rst_i      (RESET),
    .eval_i     (eval_stb),
    .deb_clr_i  (tmo_hit),
    .irq_clr_i  (IRQ_CLR),
    .sample_i   (sample_q),
    .stable_o   (STABLE_Q),
    .chg_mask_o (CHG_MASK),
    .valid_o    (VALID),
    .irq_o      (IRQ)
  );

  assign RD_START = (state_q == ST_START);
  assign BUSY     = (state_q == ST_START) || (state_q == ST_WAIT) || (state_q == ST_EVAL);
  assign TMO_ERR  = tmo_err_q;

endmodule

// File: tb/tb_hc165_scan_ctrl.sv
// Bench for hc165_scan_ctrl: timing-based reference model with per-cycle
// compare, directed scenarios with literal expectations, then random traffic.
module tb_hc165_scan_ctrl;

  localparam int W      = 16;
  localparam int PERIOD = 40;
  localparam int DEB_N  = 3;
  localparam int TMO    = 64;

  logic         MCLK = 1'b0;
  logic         RESET = 1'b1;
  logic         SCAN_EN = 1'b0;
  logic         SCAN_REQ = 1'b0;
  logic         RD_DONE = 1'b0;
  logic [W-1:0] RD_DATA = '0;
  logic         IRQ_CLR = 1'b0;
  logic         RD_START, VALID, IRQ, BUSY, TMO_ERR;
  logic [W-1:0] STABLE_Q, CHG_MASK;

  int checks = 0;
  int errors = 0;

  hc165_scan_ctrl #(.W(W), .PERIOD(PERIOD), .DEB_N(DEB_N), .TMO(TMO)) dut (
    .MCLK(MCLK), .RESET(RESET), .SCAN_EN(SCAN_EN), .SCAN_REQ(SCAN_REQ),
    .RD_START(RD_START), .RD_DONE(RD_DONE), .RD_DATA(RD_DATA),
    .STABLE_Q(STABLE_Q), .CHG_MASK(CHG_MASK), .VALID(VALID), .IRQ(IRQ),
    .IRQ_CLR(IRQ_CLR), .BUSY(BUSY), .TMO_ERR(TMO_ERR)
  );

  always #5 MCLK = ~MCLK;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // ---------------- reader emulation ----------------
  logic [W-1:0] rdr_word = 16'h00A5;
  logic [W-1:0] rdr_q[$];
  bit           rdr_hang = 1'b0;
  bit           rdr_random = 1'b0;
  bit           r_hang;
  logic [W-1:0] r_word;
  int           r_dly;

  initial begin : reader
    forever begin
      @(negedge MCLK);
      if (RD_START === 1'b1) begin
        r_hang = rdr_hang;
        r_word = rdr_word;
        if (rdr_q.size() > 0) r_word = rdr_q.pop_front();
        if (rdr_random) begin
          r_hang = ($urandom_range(0, 9) == 0);
          case ($urandom_range(0, 3))
            0: r_word = 16'h00A5;
            1: r_word = 16'h00A4;
            2: r_word = 16'h1234;
            default: r_word = 16'($urandom);
          endcase
        end
        if (!r_hang) begin
          r_dly = $urandom_range(2, 6);
          repeat (r_dly) @(posedge MCLK);
          #1;
          RD_DATA = r_word;
          RD_DONE = 1'b1;
          repeat (2) @(posedge MCLK);
          #1;
          RD_DONE = 1'b0;
          RD_DATA = 16'($urandom);
        end
      end
    end
  end

  // ---------------- reference model (cycle timestamps) ----------------
  // A scan is described by its start cycle and the cycle it frees the
  // controller; the debouncer by the history of the last DEB_N samples.
  int           cyc = 0;
  int           m_per, m_scan_s, m_end, m_pub_c;
  bit           m_pend, m_prev_done, m_valid, m_irq, m_tmo;
  logic [W-1:0] m_stable, m_mask, m_pub_sample;
  logic [W-1:0] m_hist[$];
  bit           t_rs, t_bz, t_rise, t_tmo, t_tick, t_acc;

  function automatic bit m_busy(input int c);
    return (m_scan_s >= 0) && (c >= m_scan_s) && (m_end < 0 || c < m_end);
  endfunction

  task automatic model_eval(input bit clr);
    m_hist.push_back(m_pub_sample);
    if (m_hist.size() > DEB_N) m_hist.delete(0);
    t_acc = (m_hist.size() == DEB_N);
    foreach (m_hist[k]) if (m_hist[k] != m_pub_sample) t_acc = 1'b0;
    if (clr) m_mask = '0;
    if (t_acc && (!m_valid || m_pub_sample != m_stable)) begin
      if (m_valid) m_mask = m_mask | (m_pub_sample ^ m_stable);
      m_stable = m_pub_sample;
      m_valid  = 1'b1;
    end
  endtask

  // Advance the model over the cycle that just ended.
  always @(posedge MCLK) begin
    if (RESET) begin
      m_per = 0; m_pend = 0; m_scan_s = -1; m_end = -1; m_pub_c = -1;
      m_prev_done = 0; m_stable = '0; m_mask = '0; m_valid = 0; m_irq = 0; m_tmo = 0;
      m_hist.delete();
    end else begin
      t_rs   = (cyc == m_scan_s);
      t_bz   = m_busy(cyc);
      t_rise = RD_DONE && !m_prev_done;
      m_prev_done = RD_DONE;
      t_tmo  = 1'b0;
      if (m_scan_s >= 0 && m_end < 0 && cyc > m_scan_s) begin
        if (t_rise) begin
          m_end = cyc + 2; m_pub_c = cyc + 1; m_pub_sample = RD_DATA;
        end else if (cyc == m_scan_s + TMO) begin
          m_end = cyc + 1; t_tmo = 1'b1; m_hist.delete();
        end
      end
      if (cyc == m_pub_c) model_eval(IRQ_CLR);
      else if (IRQ_CLR) m_mask = '0;
      m_irq = |m_mask;
      if (t_tmo) m_tmo = 1'b1;
      else if (IRQ_CLR) m_tmo = 1'b0;
      t_tick = SCAN_EN && (m_per == PERIOD - 1);
      m_per  = (SCAN_EN && !t_tick) ? m_per + 1 : 0;
      if (!t_bz && m_pend) begin
        m_scan_s = cyc + 1; m_end = -1;
      end
      m_pend = (m_pend && !t_rs) || t_tick || SCAN_REQ;
    end
    cyc++;
  end

  // Per-cycle comparison of every output against the model.
  always @(negedge MCLK) begin
    if (!RESET) begin
      check("rd_start", RD_START, (cyc == m_scan_s));
      check("busy", BUSY, m_busy(cyc));
      check("stable_q", STABLE_Q, m_stable);
      check("chg_mask", CHG_MASK, m_mask);
      check("valid", VALID, m_valid);
      check("irq", IRQ, m_irq);
      check("tmo_err", TMO_ERR, m_tmo);
    end
  end

  // RD_START observation for the directed literal checks.
  int n_starts = 0;
  int last_start = -1;
  int last_gap = -1;
  always @(negedge MCLK) begin
    if (!RESET && RD_START === 1'b1) begin
      n_starts++;
      if (last_start >= 0) last_gap = cyc - last_start;
      last_start = cyc;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic tick1();
    @(posedge MCLK);
    #1;
  endtask

  task automatic pulse_req();
    SCAN_REQ = 1'b1;
    tick1();
    SCAN_REQ = 1'b0;
  endtask

  task automatic pulse_clr();
    IRQ_CLR = 1'b1;
    tick1();
    IRQ_CLR = 1'b0;
  endtask

  int  lat;
  bit  ok;

  initial begin
    // Reset state
    repeat (3) @(posedge MCLK);
    @(negedge MCLK);
    check("rst_stable", STABLE_Q, 16'h0000);
    check("rst_valid", VALID, 1'b0);
    check("rst_busy", BUSY, 1'b0);
    check("rst_rd_start", RD_START, 1'b0);
    tick1();
    RESET = 1'b0;

    // 1: periodic scanning, first publish after three identical samples
    SCAN_EN = 1'b1;
    n_starts = 0;
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge MCLK);
      if (VALID === 1'b1) begin ok = 1'b1; break; end
    end
    check("p1_valid_seen", ok, 1'b1);
    check("p1_starts", n_starts, 3);
    check("p1_gap", last_gap, PERIOD);
    check("p1_stable", STABLE_Q, 16'h00A5);
    check("p1_mask", CHG_MASK, 16'h0000);
    check("p1_irq", IRQ, 1'b0);

    // 2: bit 0 changes
    rdr_word = 16'h00A4;
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge MCLK);
      if (STABLE_Q === 16'h00A4) begin ok = 1'b1; break; end
    end
    check("p2_publish_seen", ok, 1'b1);
    check("p2_mask", CHG_MASK, 16'h0001);
    check("p2_irq", IRQ, 1'b1);
    tick1();
    pulse_clr();
    @(negedge MCLK);
    check("p2_mask_clr", CHG_MASK, 16'h0000);
    check("p2_irq_clr", IRQ, 1'b0);

    // 3: glitch rejection
    rdr_word = 16'h00A5;
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge MCLK);
      if (STABLE_Q === 16'h00A5) begin ok = 1'b1; break; end
    end
    check("p3_back_a5", ok, 1'b1);
    tick1();
    pulse_clr();
    rdr_q.push_back(16'h0FFF);
    rdr_q.push_back(16'h0FFF);
    rdr_q.push_back(16'h00A5);
    rdr_q.push_back(16'h00A5);
    n_starts = 0;
    for (int i = 0; i < 400 && n_starts < 6; i++) tick1();
    repeat (20) tick1();
    check("p3_stable", STABLE_Q, 16'h00A5);
    check("p3_irq", IRQ, 1'b0);

    // 4: one-shot request latency and collapse of a request during WAIT
    SCAN_EN = 1'b0;
    repeat (60) tick1();
    SCAN_REQ = 1'b1;
    tick1();
    SCAN_REQ = 1'b0;
    lat = 1;
    ok = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge MCLK);
      if (RD_START === 1'b1) begin ok = 1'b1; break; end
      lat++;
    end
    check("p4_start_seen", ok, 1'b1);
    check("p4_latency", lat, 2);
    tick1();
    check("p4_busy_wait", BUSY, 1'b1);
    n_starts = 0;
    pulse_req();
    repeat (100) tick1();
    check("p4_extra_scans", n_starts, 1);

    // 5: timeout
    rdr_hang = 1'b1;
    pulse_req();
    ok = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge MCLK);
      if (RD_START === 1'b1) begin ok = 1'b1; break; end
    end
    check("p5_start_seen", ok, 1'b1);
    lat = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge MCLK);
      lat++;
      if (TMO_ERR === 1'b1) break;
    end
    // Counter hits TMO-1 in WAIT cycle 64 after RD_START; flag visible next cycle.
    check("p5_tmo_cycle", lat, TMO + 1);
    check("p5_idle", BUSY, 1'b0);
    rdr_hang = 1'b0;
    tick1();
    n_starts = 0;
    pulse_req();
    repeat (30) tick1();
    check("p5_next_scan", n_starts, 1);
    check("p5_tmo_sticky", TMO_ERR, 1'b1);
    pulse_clr();
    @(negedge MCLK);
    check("p5_tmo_clr", TMO_ERR, 1'b0);

    // 6: asynchronous reset during WAIT, late done edge ignored
    tick1();
    pulse_req();
    for (int i = 0; i < 10; i++) begin
      @(negedge MCLK);
      if (RD_START === 1'b1) break;
    end
    @(posedge MCLK);
    #2;
    RESET = 1'b1;
    #1;
    check("p6_async_stable", STABLE_Q, 16'h0000);
    check("p6_async_valid", VALID, 1'b0);
    check("p6_async_busy", BUSY, 1'b0);
    check("p6_async_mask", CHG_MASK, 16'h0000);
    tick1();
    RESET = 1'b0;
    n_starts = 0;
    repeat (30) tick1();
    check("p6_no_start", n_starts, 0);
    check("p6_valid", VALID, 1'b0);

    // 7: random traffic against the model
    rdr_random = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      tick1();
      SCAN_REQ = ($urandom_range(0, 15) == 0);
      IRQ_CLR  = ($urandom_range(0, 23) == 0);
      if (i % 250 == 0) SCAN_EN = ($urandom_range(0, 2) != 0);
      if (i == 1500) begin
        #1;
        RESET = 1'b1;
        tick1();
        RESET = 1'b0;
      end
    end
    SCAN_REQ = 1'b0;
    IRQ_CLR  = 1'b0;
    SCAN_EN  = 1'b0;
    repeat (100) tick1();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
